// File: rtl/gate_round_scheduler.sv
// gate_round_scheduler
// Command-driven sequencer for the gate array TX/RX handshake. A run command
// (round count, per-round timeout) starts one sync pulse followed by rounds of
// launch -> wait-for-all-ready -> pull. Completion status, completed-round
// count and the gates that failed to become ready are held until the next
// command is accepted. Handshake/pulse outputs are a Moore decode of the state,
// registered so they leave the block straight from flops.
module gate_round_scheduler #(
  parameter int GATE_NUMBER = 4,
  parameter int CNT_W       = 16,
  parameter int TMO_W       = 12
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [CNT_W-1:0]       i_cmd_rounds,
  input  logic [TMO_W-1:0]       i_cmd_timeout,
  input  logic                   i_abort,
  input  logic [GATE_NUMBER-1:0] i_tx_ready,
  input  logic [GATE_NUMBER-1:0] i_rx_ready,
  output logic                   o_gen_sync,
  output logic                   o_tx_start,
  output logic                   o_rx_pull,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [1:0]             o_status,
  output logic [GATE_NUMBER-1:0] o_fail_mask,
  output logic [CNT_W-1:0]       o_rounds_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SYNC,
    S_LAUNCH,
    S_WAIT,
    S_PULL,
    S_DONE
  } state_t;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  typedef struct packed {
    logic cmd_ready;
    logic busy;
    logic gen_sync;
    logic tx_start;
    logic rx_pull;
    logic done;
  } outs_t;

  // Moore decode: every handshake/pulse output is a function of state alone.
  function automatic outs_t decode(input state_t s);
    outs_t o;
    o           = '0;
    o.cmd_ready = (s == S_IDLE);
    o.busy      = (s != S_IDLE);
    o.gen_sync  = (s == S_SYNC);
    o.tx_start  = (s == S_LAUNCH);
    o.rx_pull   = (s == S_PULL);
    o.done      = (s == S_DONE);
    return o;
  endfunction

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       rounds_q, rounds_d;
  logic [TMO_W-1:0]       timeout_q, timeout_d;
  logic [TMO_W-1:0]       wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]       rounds_done_q, rounds_done_d;
  logic [1:0]             status_q, status_d;
  logic [GATE_NUMBER-1:0] fail_mask_q, fail_mask_d;
  outs_t                  outs_q, outs_d;

  logic                   all_ready;
  logic                   tmo_hit;

  assign all_ready = &(i_tx_ready & i_rx_ready);
  // A zero timeout disables the limit; otherwise the T-th WAIT cycle is the last.
  assign tmo_hit   = (timeout_q != '0) && (wait_cnt_q == timeout_q - 1'b1);

  // Next-state and datapath update for the run sequencer.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    state_d       = state_q;
    rounds_d      = rounds_q;
    timeout_d     = timeout_q;
    wait_cnt_d    = wait_cnt_q;
    rounds_done_d = rounds_done_q;
    status_d      = status_q;
    fail_mask_d   = fail_mask_q;

    unique case (state_q)
      S_IDLE: begin
        // Abort is ignored here, so a same-cycle command still gets accepted.
        if (i_cmd_valid) begin
          rounds_d      = i_cmd_rounds;
          timeout_d     = i_cmd_timeout;
          rounds_done_d = '0;
          status_d      = ST_OK;
          fail_mask_d   = '0;
          state_d       = (i_cmd_rounds == '0) ? S_DONE : S_SYNC;
        end
      end

      S_SYNC: begin
        if (i_abort) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else begin
          state_d  = S_LAUNCH;
        end
      end

      S_LAUNCH: begin
        wait_cnt_d = '0;
        if (i_abort) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else begin
          state_d  = S_WAIT;
        end
      end

      S_WAIT: begin
        wait_cnt_d = wait_cnt_q + 1'b1;
        // Priority: abort, then readiness, then timeout.
        if (i_abort) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (all_ready) begin
          state_d  = S_PULL;
        end else if (tmo_hit) begin
          status_d    = ST_TIMEOUT;
          fail_mask_d = ~(i_tx_ready & i_rx_ready);
          state_d     = S_DONE;
        end
      end

      S_PULL: begin
        // The pulled round counts even when the run is aborted in this cycle.
        rounds_done_d = rounds_done_q + 1'b1;
        if (i_abort) begin
          status_d = ST_ABORT;
          state_d  = S_DONE;
        end else if (rounds_done_d == rounds_q) begin
          state_d  = S_DONE;
        end else begin
          state_d  = S_LAUNCH;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    outs_d = decode(state_d);
  end

  // State, datapath and registered output flops with asynchronous reset.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q       <= S_IDLE;
      rounds_q      <= '0;
      timeout_q     <= '0;
      wait_cnt_q    <= '0;
      rounds_done_q <= '0;
      status_q      <= ST_OK;
      fail_mask_q   <= '0;
      outs_q        <= decode(S_IDLE);
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q       <= state_d;
      rounds_q      <= rounds_d;
      timeout_q     <= timeout_d;
      wait_cnt_q    <= wait_cnt_d;
      rounds_done_q <= rounds_done_d;
      status_q      <= status_d;
      fail_mask_q   <= fail_mask_d;
      outs_q        <= outs_d;
    end
  end

  assign o_cmd_ready   = outs_q.cmd_ready;
  assign o_busy        = outs_q.busy;
  assign o_gen_sync    = outs_q.gen_sync;
  assign o_tx_start    = outs_q.tx_start;
  assign o_rx_pull     = outs_q.rx_pull;
  assign o_done        = outs_q.done;
  assign o_status      = status_q;
  assign o_fail_mask   = fail_mask_q;
  assign o_rounds_done = rounds_done_q;

endmodule

// File: tb/tb_gate_round_scheduler.sv
// Testbench for gate_round_scheduler: a table of run commands, each with its
// expected outcome pushed to a scoreboard when driven and compared when o_done
// appears, plus hand-written sequences for pulse timing and mid-run reset.
module tb_gate_round_scheduler;

  localparam int GATE_NUMBER = 4;
  localparam int CNT_W       = 16;
  localparam int TMO_W       = 12;

  typedef struct {
    int         rounds;
    int         tmo;
    int         bad_after;   // rx_ready forced to rx_bad once this many pulls seen
    logic [3:0] rx_bad;
    int         rise_off;    // cycle offset where readiness is forced good (-1 none)
    int         abort_off;   // cycle offset of a one-cycle abort (-1 none)
    int         busy_off;    // cycle offset of a cmd_valid pulse while busy (-1 none)
    logic [1:0] exp_status;
    int         exp_rdone;
    logic [3:0] exp_mask;
    int         exp_lat;     // o_done cycle relative to the accept cycle
    int         exp_sync;
    int         exp_tx;
    int         exp_pull;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   cmd_valid = 1'b0;
  logic                   cmd_ready;
  logic [CNT_W-1:0]       cmd_rounds = '0;
  logic [TMO_W-1:0]       cmd_timeout = '0;
  logic                   abort = 1'b0;
  logic [GATE_NUMBER-1:0] tx_ready;
  logic [GATE_NUMBER-1:0] rx_ready;
  logic                   gen_sync, tx_start, rx_pull, busy, done;
  logic [1:0]             status;
  logic [GATE_NUMBER-1:0] fail_mask;
  logic [CNT_W-1:0]       rounds_done;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         n_sync = 0, n_tx = 0, n_pull = 0;
  int         sync_log[$], tx_log[$], pull_log[$];
  vec_t       exp_q[$];
  vec_t       vecs[11];
  int         run_idx = 0;
  logic       done_seen = 1'b0;
  int         bad_after = 99;
  logic [3:0] rx_bad = 4'hF;
  logic       force_good = 1'b0;

  assign tx_ready = '1;
  assign rx_ready = (n_pull >= bad_after && !force_good) ? rx_bad : '1;

  gate_round_scheduler #(
    .GATE_NUMBER(GATE_NUMBER),
    .CNT_W      (CNT_W),
    .TMO_W      (TMO_W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_rounds (cmd_rounds),
    .i_cmd_timeout(cmd_timeout),
    .i_abort      (abort),
    .i_tx_ready   (tx_ready),
    .i_rx_ready   (rx_ready),
    .o_gen_sync   (gen_sync),
    .o_tx_start   (tx_start),
    .o_rx_pull    (rx_pull),
    .o_busy       (busy),
    .o_done       (done),
    .o_status     (status),
    .o_fail_mask  (fail_mask),
    .o_rounds_done(rounds_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: tracks pulses since the last accept and scores each o_done.
  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid && cmd_ready) begin
        acc_cyc = cyc;
        n_sync = 0; n_tx = 0; n_pull = 0;
        sync_log.delete(); tx_log.delete(); pull_log.delete();
      end
      if (gen_sync) begin n_sync++; sync_log.push_back(cyc - acc_cyc); end
      if (tx_start) begin n_tx++;   tx_log.push_back(cyc - acc_cyc);   end
      if (rx_pull)  begin n_pull++; pull_log.push_back(cyc - acc_cyc); end
      if (done) begin
        vec_t e;
        done_seen = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("v%0d_status", run_idx),  int'(status),      int'(e.exp_status));
          check($sformatf("v%0d_rdone", run_idx),   int'(rounds_done), e.exp_rdone);
          check($sformatf("v%0d_mask", run_idx),    int'(fail_mask),   int'(e.exp_mask));
          check($sformatf("v%0d_latency", run_idx), cyc - acc_cyc,     e.exp_lat);
          check($sformatf("v%0d_n_sync", run_idx),  n_sync,            e.exp_sync);
          check($sformatf("v%0d_n_tx", run_idx),    n_tx,              e.exp_tx);
          check($sformatf("v%0d_n_pull", run_idx),  n_pull,            e.exp_pull);
        end
      end
    end
  end

  // Drive one command from the table; inputs change 1 time unit after posedge.
  task automatic run_vec(input vec_t v, input int idx);
    int k_wait;
    run_idx   = idx;
    exp_q.push_back(v);
    done_seen = 1'b0;
    bad_after = v.bad_after;
    rx_bad    = v.rx_bad;
    force_good = 1'b0;
    @(posedge clk); #1;
    k_wait = 0;
    while (!cmd_ready && k_wait < 50) begin
      @(posedge clk); #1;
      k_wait++;
    end
    cmd_rounds  = CNT_W'(v.rounds);
    cmd_timeout = TMO_W'(v.tmo);
    cmd_valid   = 1'b1;
    abort       = (v.abort_off == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    abort     = 1'b0;
    for (int off = 1; off < 200 && !done_seen; off++) begin
      abort     = (off == v.abort_off);
      cmd_valid = (off == v.busy_off);
      if (off == v.rise_off) force_good = 1'b1;
      @(posedge clk); #1;
    end
    abort      = 1'b0;
    cmd_valid  = 1'b0;
    force_good = 1'b0;
    check($sformatf("v%0d_done_in_budget", idx), int'(done_seen), 1);
    @(negedge clk);
    check($sformatf("v%0d_idle_after_done", idx), int'(busy), 0);
  endtask

  initial begin
    int exp_tx_cyc[3];
    int exp_pull_cyc[3];
    logic saw_activity;

    //            rnd tmo bad  rx_bad  rise abrt busy  st    rd mask   lat sy tx pl
    vecs[0]  = '{3, 0, 99, 4'hF,    -1, -1, -1, 2'b00, 3, 4'h0,    11, 1, 3, 3};
    vecs[1]  = '{2, 5, 1,  4'b1011, -1, -1, -1, 2'b01, 1, 4'b0100, 11, 1, 2, 1};
    vecs[2]  = '{2, 4, 99, 4'hF,    -1, 8,  -1, 2'b00, 2, 4'h0,    8,  1, 2, 2};
    vecs[3]  = '{0, 7, 99, 4'hF,    -1, -1, -1, 2'b00, 0, 4'h0,    1,  0, 0, 0};
    vecs[4]  = '{4, 0, 1,  4'h0,    -1, 8,  3,  2'b10, 1, 4'h0,    9,  1, 2, 1};
    vecs[5]  = '{1, 3, 0,  4'h0,    5,  -1, -1, 2'b00, 1, 4'h0,    7,  1, 1, 1};
    vecs[6]  = '{1, 3, 0,  4'h0,    6,  -1, -1, 2'b01, 0, 4'hF,    6,  1, 1, 0};
    vecs[7]  = '{3, 0, 99, 4'hF,    -1, 4,  -1, 2'b10, 1, 4'h0,    5,  1, 1, 1};
    vecs[8]  = '{3, 0, 99, 4'hF,    -1, 1,  -1, 2'b10, 0, 4'h0,    2,  1, 0, 0};
    vecs[9]  = '{1, 1, 0,  4'b0110, -1, -1, -1, 2'b01, 0, 4'b1001, 4,  1, 1, 0};
    vecs[10] = '{1, 0, 99, 4'hF,    -1, 0,  -1, 2'b00, 1, 4'h0,    5,  1, 1, 1};
    exp_tx_cyc   = '{2, 5, 8};
    exp_pull_cyc = '{4, 7, 10};

    // Power-on reset values.
    #2 rst = 1'b1;
    #10;
    check("rst_cmd_ready", int'(cmd_ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_pulses", int'({gen_sync, tx_start, rx_pull, done}), 0);
    check("rst_status", int'(status), 0);
    check("rst_mask", int'(fail_mask), 0);
    check("rst_rdone", int'(rounds_done), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Three always-ready rounds: exact pulse cycles relative to accept.
    run_vec(vecs[0], 0);
    check("v0_sync_count", sync_log.size(), 1);
    if (sync_log.size() == 1) check("v0_sync_cycle", sync_log[0], 1);
    check("v0_tx_count", tx_log.size(), 3);
    check("v0_pull_count", pull_log.size(), 3);
    for (int i = 0; i < 3 && i < tx_log.size(); i++)
      check($sformatf("v0_tx_cycle%0d", i), tx_log[i], exp_tx_cyc[i]);
    for (int i = 0; i < 3 && i < pull_log.size(); i++)
      check($sformatf("v0_pull_cycle%0d", i), pull_log[i], exp_pull_cyc[i]);

    for (int i = 1; i < 11; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of WAIT of round 2.
    run_idx    = 99;
    done_seen  = 1'b0;
    bad_after  = 1;
    rx_bad     = 4'h0;
    @(posedge clk); #1;
    cmd_rounds  = CNT_W'(3);
    cmd_timeout = TMO_W'(0);
    cmd_valid   = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (6) begin @(posedge clk); #1; end
    check("mid_wait_busy", int'(busy), 1);
    check("mid_wait_rdone", int'(rounds_done), 1);
    rst = 1'b1;
    #2;
    check("async_rst_cmd_ready", int'(cmd_ready), 1);
    check("async_rst_busy", int'(busy), 0);
    check("async_rst_rdone", int'(rounds_done), 0);
    check("async_rst_pulses", int'({gen_sync, tx_start, rx_pull, done}), 0);
    @(posedge clk); #1 rst = 1'b0;
    bad_after = 99;
    saw_activity = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (gen_sync || tx_start || rx_pull || done || busy) saw_activity = 1'b1;
    end
    check("quiet_after_reset", int'(saw_activity), 0);

    check("scoreboard_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gate_round_scheduler.md
# gate_round_scheduler

- Command-driven sequencer for the gate array's TX/RX handshake.
- Accepts a run command (round count, per-round timeout) over a valid/ready handshake.
- Issues one sync pulse, then repeats launch → wait-for-all-ready → pull for the requested number of rounds.
- Reports completion status, rounds completed and the gates that failed to become ready. Sits between the host control logic and the gate array.

## Interface
- GATE_NUMBER, 4, number of gates (width of ready buses)
- CNT_W, 16, width of round count and completed-round counter
- TMO_W, 12, width of per-round timeout
- i_clk  in  1  clock
- i_rst  in  1  reset, asynchronous, active-high
- i_cmd_valid  in  1  run request
- o_cmd_ready  out  1  high only in IDLE; command accepted on i_cmd_valid & o_cmd_ready
- i_cmd_rounds  in  CNT_W  rounds to run; 0 legal
- i_cmd_timeout  in  TMO_W  max WAIT cycles per round; 0 = no timeout
- i_abort  in  1  terminate active run
- i_tx_ready  in  GATE_NUMBER  per-gate TX ready
- i_rx_ready  in  GATE_NUMBER  per-gate RX ready
- o_gen_sync  out  1  one-cycle sync pulse at run start
- o_tx_start  out  1  one-cycle pulse per round launch
- o_rx_pull  out  1  one-cycle pulse per completed round
- o_busy  out  1  high in any state except IDLE
- o_done  out  1  one-cycle pulse at run end
- o_status  out  2  00 OK, 01 TIMEOUT, 10 ABORT; valid from o_done until next accept
- o_fail_mask  out  GATE_NUMBER  bit g = ~(i_tx_ready[g] & i_rx_ready[g]) captured at timeout; 0 otherwise
- o_rounds_done  out  CNT_W  rounds completed in current/last run

## Operation
- States: IDLE, SYNC, LAUNCH, WAIT, PULL, DONE. o_gen_sync/o_tx_start/o_rx_pull/o_done/o_busy/o_cmd_ready are decoded from state only (Moore).
- all_ready = &(i_tx_ready & i_rx_ready).
- IDLE: on accept, latch rounds/timeout, clear o_rounds_done, o_status, o_fail_mask. If rounds==0 → DONE (OK). Else → SYNC.
- SYNC: o_gen_sync=1 → LAUNCH.
- LAUNCH: o_tx_start=1; clear wait counter → WAIT.
- WAIT: wait counter increments each cycle. all_ready → PULL (ready beats timeout in the same cycle). Else if timeout≠0 and counter==timeout−1 → DONE, TIMEOUT, capture o_fail_mask. Otherwise stay in WAIT.
- PULL: o_rx_pull=1; o_rounds_done increments. If the new count == rounds → DONE (OK), else → LAUNCH.
- DONE: o_done=1 → IDLE. Status, mask and count hold until the next accept.
- i_abort in SYNC/LAUNCH/WAIT/PULL:
  - Next state is DONE with ABORT; abort has priority over ready and timeout.
  - Abort in PULL still counts that round.
  - Abort in IDLE or DONE is ignored.
  - Accept and abort in the same IDLE cycle: the command is accepted.
- i_cmd_valid while busy is ignored (o_cmd_ready=0).
- o_rounds_done saturates naturally: it cannot exceed the latched rounds value.
- Ready inputs are sampled only in WAIT. Readiness in other states has no effect.

## Timing
- Reset (async, immediate):
  - state IDLE; o_cmd_ready=1;
  - all pulses 0, o_busy=0;
  - o_status=00, o_fail_mask=0, o_rounds_done=0.
- Accept at edge k:
  - o_gen_sync high in cycle k+1;
  - first o_tx_start in k+2;
  - WAIT from k+3.
- Minimum round period is 3 cycles (LAUNCH, WAIT, PULL). N rounds, always ready: o_tx_start at k+2+3i, o_rx_pull at k+4+3i, o_done at k+2+3N.
- rounds==0: o_done at k+1, no sync, no launch.
- Timeout T: exactly T cycles in WAIT, then o_done in the following cycle.
- Abort sampled in cycle c (active state): o_done in c+1.
- Earliest next accept: the cycle after o_done.

## Test plan
- Reset mid-WAIT with i_rst pulse:
  - → outputs return immediately to reset values (o_cmd_ready=1, o_rounds_done=0);
  - → no pulse after release until a new command.
- rounds=3, timeout=0, all ready tied 1, accept at cycle 0:
  - → sync@1; tx_start@2,5,8; rx_pull@4,7,10; done@11;
  - → status 00, rounds_done 3.
- GATE_NUMBER=4, rounds=2, timeout=5; after first pull, rx_ready=4'b1011 held:
  - → exactly 5 WAIT cycles, then done;
  - → status 01, fail_mask 4'b0100, rounds_done 1.
- rounds=0, timeout=7:
  - → done the cycle after accept; no sync/tx_start/rx_pull; status 00, rounds_done 0.
- rounds=4, ready held low in round 2, i_abort for 1 cycle in WAIT, plus i_cmd_valid pulsed while busy:
  - → done next cycle, status 10, rounds_done 1;
  - → the busy command is not accepted.
- Ready and timeout coinciding: timeout=3, all_ready rises on the 3rd WAIT cycle:
  - → PULL taken, no timeout, status 00 at end.
